uart_rx_fifo: RTL

Parametrised UART receiver with 16x oversampling, configurable frame format (data bits, parity, stop bits), per-frame error flags and a show-ahead receive FIFO with a valid/ready output handshake. It replaces the fixed 8N1, baud-clock-driven receiver path inside `Top`. It runs entirely on the system clock, with no separate baud clock. It drives the downstream byte consumer (loopback/TX path or register interface).

---
 rtl/uart_rx_fifo.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/uart_rx_fifo.sv
// UART receiver with 16x oversampling, configurable frame format and a
// show-ahead receive FIFO carrying per-frame parity/framing error flags.
module uart_rx_fifo #(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD_RATE  = 9600,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] out_data,
  output logic                 out_perr,
  output logic                 out_ferr,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 overrun,
  input  logic                 err_clr,
  output logic                 busy
);

  localparam int DIV_RAW = CLK_FREQ / (BAUD_RATE * 16);
  localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int TW      = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int PW      = $clog2(FIFO_DEPTH);
  localparam int CW      = PW + 1;
  localparam int EW      = DATA_BITS + 2;

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

  logic [TW-1:0]        tick_cnt;
  logic                 tick;
  logic                 rx_meta, rxs;
  state_t               state;
  logic [3:0]           s_cnt;
  logic [3:0]           bit_cnt;
  logic [DATA_BITS-1:0] shift;
  logic                 perr_reg, ferr_reg, busy_reg;
  logic                 push, push_ferr;

  logic [EW-1:0]        mem [FIFO_DEPTH];
  logic [PW-1:0]        rd_ptr, wr_ptr;
  logic [CW-1:0]        count;
  logic                 full, pop, wr_en;
  logic [EW-1:0]        head;

  assign tick = (tick_cnt == TW'(DIV - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tick_cnt <= '0;
      rx_meta  <= 1'b1;
      rxs      <= 1'b1;
    end else begin
      tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
      rx_meta  <= rx;
      rxs      <= rx_meta;
    end
  end

  // The last stop sample is the push strobe; the state machine leaves STOP on the same tick.
  assign push      = (state == STOP) && tick && (s_cnt == 4'd15) && (bit_cnt == 4'(STOP_BITS - 1));
  assign push_ferr = ferr_reg | ~rxs;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      s_cnt    <= '0;
      bit_cnt  <= '0;
      shift    <= '0;
      perr_reg <= 1'b0;
      ferr_reg <= 1'b0;
      busy_reg <= 1'b0;
    end else if (tick) begin
      case (state)
        IDLE: begin
          if (!rxs) begin
            state    <= START;
            s_cnt    <= '0;
            busy_reg <= 1'b1;
          end
        end
        START: begin
          if (s_cnt == 4'd7) begin
            if (rxs) begin
              state    <= IDLE;
              busy_reg <= 1'b0;
            end else begin
              state    <= DATA;
              s_cnt    <= '0;
              bit_cnt  <= '0;
              perr_reg <= 1'b0;
              ferr_reg <= 1'b0;
            end
          end else begin
            s_cnt <= s_cnt + 1'b1;
          end
        end
        DATA: begin
          s_cnt <= s_cnt + 1'b1;
          if (s_cnt == 4'd15) begin
            shift <= {rxs, shift[DATA_BITS-1:1]};
            if (bit_cnt == 4'(DATA_BITS - 1)) begin
              bit_cnt <= '0;
              state   <= (PARITY != 0) ? PAR : STOP;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        PAR: begin
          s_cnt <= s_cnt + 1'b1;
          if (s_cnt == 4'd15) begin
            perr_reg <= (PARITY == 1) ? ~(^shift ^ rxs) : (^shift ^ rxs);
            state    <= STOP;
          end
        end
        STOP: begin
          s_cnt <= s_cnt + 1'b1;
          if (s_cnt == 4'd15) begin
            ferr_reg <= push_ferr;
            if (bit_cnt == 4'(STOP_BITS - 1)) begin
              state    <= IDLE;
              busy_reg <= 1'b0;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        default: begin
          state    <= IDLE;
          busy_reg <= 1'b0;
        end
      endcase
    end
  end

  assign busy = busy_reg;

  // A pop in the same cycle frees the slot, so a push into a full FIFO is still accepted.
  assign full      = (count == CW'(FIFO_DEPTH));
  assign out_valid = (count != '0);
  assign pop       = out_valid & out_ready;
  assign wr_en     = push & (~full | pop);

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= {perr_reg, push_ferr, shift};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count   <= '0;
      overrun <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      if (wr_en && !pop)      count <= count + 1'b1;
      else if (!wr_en && pop) count <= count - 1'b1;
      if (push && full && !pop) overrun <= 1'b1;
      else if (err_clr)         overrun <= 1'b0;
    end
  end

  assign head = mem[rd_ptr];
  assign {out_perr, out_ferr, out_data} = out_valid ? head : '0;

endmodule
